// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: streams x0..x31 from an rf read port (dump_ra/dump_rd) out as valid/ready words (out_addr/out_data/out_last) with busy/done status; define RF_DUMP_CSUM_EN to append an XOR checksum word
module rf_dump_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  dump_ra,
  input  logic [31:0] dump_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, READ, SEND, FIN, CSUM} state_t;
  state_t state, nxt;
  logic [4:0] idx;
  logic hs, end_idx;
  assign hs = out_valid && out_ready;
  assign end_idx = idx == 5'd31;
  assign dump_ra = state == READ ? idx : 5'd0;
  assign busy = state != IDLE;
  assign done = state == FIN;
`ifdef RF_DUMP_CSUM_EN
  logic [31:0] acc;
  assign out_valid = state == SEND || state == CSUM;
`else
  assign out_valid = state == SEND;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? READ : IDLE;
      READ: nxt = SEND;
`ifdef RF_DUMP_CSUM_EN
      SEND: nxt = !hs ? SEND : end_idx ? CSUM : READ;
      CSUM: nxt = hs ? FIN : CSUM;
`else
      SEND: nxt = !hs ? SEND : end_idx ? FIN : READ;
`endif
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      out_addr <= '0;
      out_data <= '0;
      out_last <= 1'b0;
`ifdef RF_DUMP_CSUM_EN
      acc <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        idx <= '0;
`ifdef RF_DUMP_CSUM_EN
        acc <= '0;
`endif
      end
      if (state == READ) begin
        out_data <= dump_rd;
        out_addr <= idx;
`ifdef RF_DUMP_CSUM_EN
        out_last <= 1'b0;
        acc <= acc ^ dump_rd;
`else
        out_last <= end_idx;
`endif
      end
      if (state == SEND && hs) begin
        if (!end_idx) idx <= idx + 5'd1;
`ifdef RF_DUMP_CSUM_EN
        if (end_idx) begin
          out_data <= acc;
          out_addr <= '0;
        end
        out_last <= end_idx;
      end
      if (state == CSUM && hs) out_last <= 1'b0;
`else
        out_last <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_rf_dump_ctrl.sv
// tb_rf_dump_ctrl: directed self-checking bench for rf_dump_ctrl against a model register file
module tb_rf_dump_ctrl;
  logic clk = 0, rst = 1, start = 0, out_ready = 1;
  logic [4:0] dump_ra, out_addr;
  logic [31:0] dump_rd, out_data;
  logic out_valid, out_last, busy, done;
  logic [31:0] rf [32];
  logic [31:0] golden [32];
  int tests = 0, fails = 0, done_cnt = 0;
`ifdef RF_DUMP_CSUM_EN
  localparam int NW = 33;
`else
  localparam int NW = 32;
`endif
  rf_dump_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dump_ra(dump_ra), .dump_rd(dump_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always_comb dump_rd = rf[dump_ra];
  always @(posedge clk) if (done === 1'b1) done_cnt++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_dump(input int stall_at, input int stall_n, input bit poke3, input bit noise);
    start = 1;
    @(negedge clk);
    if (!noise) start = 0;
    chk("read_state", {out_valid, busy, dump_ra}, {1'b0, 1'b1, 5'd0});
    for (int i = 0; i < NW; i++) begin
      int w = 0;
      while (!out_valid && w < 4) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("gap_w%0d", i), w, i == 32 ? 0 : 1);
      if (i == stall_at) begin
        out_ready = 0;
        if (poke3) rf[3] = 32'hDEADBEEF;
        repeat (stall_n) begin
          @(negedge clk);
          chk($sformatf("stall_w%0d", i), {out_valid, out_addr, out_data}, {1'b1, 5'(i), golden[i]});
        end
        out_ready = 1;
      end
      chk($sformatf("addr_w%0d", i), out_addr, i < 32 ? i : 0);
      chk($sformatf("data_w%0d", i), out_data, i < 32 ? golden[i] : 32'h95511559);
      chk($sformatf("last_w%0d", i), out_last, i == NW - 1);
      chk($sformatf("dump_ra_w%0d", i), dump_ra, 5'd0);
      @(negedge clk);
    end
    chk("fin", {done, out_valid, busy, out_last}, 4'b1010);
    @(negedge clk);
    start = 0;
    chk("post_fin", {done, busy, out_valid}, 3'b000);
    if (poke3) rf[3] = golden[3];
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 32; i++) golden[i] = 32'h0;
    golden[2] = 32'h87654321;
    golden[3] = 32'h12345678;
    for (int i = 0; i < 32; i++) rf[i] = golden[i];
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {out_valid, busy, done, out_last, out_addr, out_data, dump_ra},
        {4'b0000, 5'd0, 32'd0, 5'd0});
    rst = 0;
    @(negedge clk);
    chk("idle_after_reset", {out_valid, busy}, 2'b00);
    done_cnt = 0;
    do_dump(-1, 0, 0, 0);
    chk("done_count_1", done_cnt, 1);
    do_dump(5, 10, 0, 0);
    do_dump(3, 4, 1, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 60 && !(out_valid && out_addr == 5'd10); k++) @(negedge clk);
    chk("reach_w10", {out_valid, out_addr}, {1'b1, 5'd10});
    rst = 1;
    #1;
    chk("async_reset", {out_valid, busy, done, out_last, out_addr, out_data, dump_ra},
        {4'b0000, 5'd0, 32'd0, 5'd0});
    @(negedge clk);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      chk("no_resume", {out_valid, busy, done}, 3'b000);
    end
    do_dump(-1, 0, 0, 0);
    done_cnt = 0;
    do_dump(-1, 0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      chk("ignored_start", {out_valid, busy}, 2'b00);
    end
    chk("done_count_noise", done_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
